// File: rtl/mem_responder_512x8_if.sv
// Datapath-to-memory bus for the 512x8 responder.
// Four-phase handshake: MOV rises with a request and stays high until MOC is seen;
// MOC stays high until MOV is seen low, then falls, and only then may MOV rise again.
interface mem_responder_512x8_if;
   logic        MOV;
   logic        RW;
   logic [8:0]  addr;
   logic [31:0] DataIn;
   logic [5:0]  OpC;
   logic [31:0] DataOut;
   logic        MOC;
   logic        DMOC;
   logic        ERR;

   modport master (output MOV, RW, addr, DataIn, OpC,
                   input  DataOut, MOC, DMOC, ERR);
   modport slave  (input  MOV, RW, addr, DataIn, OpC,
                   output DataOut, MOC, DMOC, ERR);
endinterface

// File: rtl/mem_responder_512x8.sv
// 512x8 big-endian memory behind a MOV/MOC four-phase handshake with fixed latency,
// MIPS byte/halfword/word sizing, sign/zero extension and misalignment flagging.
module mem_responder_512x8 #(
   parameter int LATENCY   = 2,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   mem_responder_512x8_if.slave         bus,
   output logic [1:0]                   state_dbg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [3:0] LAT = 4'(LATENCY);

   logic [7:0]  Mem [0:511] = '{default: (INIT_ZERO ? 8'h00 : 8'hxx)};

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        rw_q;
   logic [8:0]  addr_q;
   logic [5:0]  op_q;
   logic [31:0] din_q;
   logic [31:0] data_q;
   logic        err_q;

   logic [1:0]  size;
   logic        sext;
   logic        is_ls;
   logic        misaligned;
   logic        fire;
   logic        wr_en;
   logic [8:0]  a1, a2, a3;
   logic [7:0]  b0, b1, b2, b3;
   logic [31:0] rd_data;

   // Unlisted opcodes are instruction fetches: word sized, no data-complete strobe.
   always_comb begin
      size  = SZ_W;
      sext  = 1'b0;
      is_ls = 1'b1;
      case (op_q)
         6'b100000: begin size = SZ_B; sext = 1'b1; end
         6'b100100: size = SZ_B;
         6'b101000: size = SZ_B;
         6'b100001: begin size = SZ_H; sext = 1'b1; end
         6'b100101: size = SZ_H;
         6'b101001: size = SZ_H;
         6'b100011: size = SZ_W;
         6'b101011: size = SZ_W;
         default:   is_ls = 1'b0;
      endcase
   end

   assign misaligned = ((size == SZ_H) && addr_q[0]) ||
                       ((size == SZ_W) && (addr_q[1:0] != 2'b00));

   assign a1 = addr_q + 9'd1;
   assign a2 = addr_q + 9'd2;
   assign a3 = addr_q + 9'd3;
   assign b0 = Mem[addr_q];
   assign b1 = Mem[a1];
   assign b2 = Mem[a2];
   assign b3 = Mem[a3];

   always_comb begin
      rd_data = {b0, b1, b2, b3};
      case (size)
         SZ_B:    rd_data = {{24{sext & b0[7]}}, b0};
         SZ_H:    rd_data = {{16{sext & b0[7]}}, b0, b1};
         default: rd_data = {b0, b1, b2, b3};
      endcase
   end

   // Counter is loaded with LATENCY and the access fires one cycle after it drains,
   // which puts MOC high LATENCY+1 edges after the accepting edge.
   assign fire  = (state == BUSY) && (cnt == 4'd0);
   assign wr_en = fire && !rw_q && !misaligned;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         rw_q   <= 1'b1;
         addr_q <= 9'd0;
         op_q   <= 6'd0;
         din_q  <= 32'd0;
         data_q <= 32'd0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.MOV) begin
                  rw_q   <= bus.RW;
                  addr_q <= bus.addr;
                  op_q   <= bus.OpC;
                  din_q  <= bus.DataIn;
                  cnt    <= LAT;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state <= DONE;
                  err_q <= misaligned;
                  if (misaligned)  data_q <= 32'd0;
                  else if (rw_q)   data_q <= rd_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               if (!bus.MOV) begin
                  state <= IDLE;
                  err_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Plain always so the array stays writable from a bench backdoor; an aborted
   // access never commits because reset has already forced the FSM out of BUSY.
   always @(posedge clk) begin
      if (wr_en) begin
         case (size)
            SZ_B: Mem[addr_q] <= din_q[7:0];
            SZ_H: begin
               Mem[addr_q] <= din_q[15:8];
               Mem[a1]     <= din_q[7:0];
            end
            default: begin
               Mem[addr_q] <= din_q[31:24];
               Mem[a1]     <= din_q[23:16];
               Mem[a2]     <= din_q[15:8];
               Mem[a3]     <= din_q[7:0];
            end
         endcase
      end
   end

   assign bus.MOC     = (state == DONE);
   assign bus.DMOC    = (state == DONE) && is_ls;
   assign bus.ERR     = err_q;
   assign bus.DataOut = data_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_mem_responder_512x8.sv
// Directed bench for mem_responder_512x8: driver tasks push expected responses,
// a negedge monitor pops and compares them on every MOC rise.
module tb_mem_responder_512x8;

  localparam int EXP_LAT = 3;  // LATENCY=2 -> MOC rises 3 edges after accept

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_IF  = 6'b000000;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  mem_responder_512x8_if bus ();

  mem_responder_512x8 #(.LATENCY(2), .INIT_ZERO(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // {data[31:0], err, dmoc}
  logic [33:0] exp_q[$];
  logic        moc_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.MOC === 1'b1 && moc_q === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_moc", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("mon_data", bus.DataOut, e[33:2]);
        check("mon_err",  {31'd0, bus.ERR},  {31'd0, e[1]});
        check("mon_dmoc", {31'd0, bus.DMOC}, {31'd0, e[0]});
      end
    end
    moc_q = bus.MOC;
  end

  // Called right after a negedge; returns right after a negedge with MOV low.
  task automatic do_req(input logic rw, input logic [8:0] a, input logic [5:0] op,
                        input logic [31:0] din, input logic [31:0] exp_d,
                        input logic exp_err, input logic exp_dmoc, input int hold_extra);
    int n;
    bit seen;
    exp_q.push_back({exp_d, exp_err, exp_dmoc});
    bus.RW = rw; bus.addr = a; bus.OpC = op; bus.DataIn = din; bus.MOV = 1'b1;
    n = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.MOC === 1'b1) seen = 1;
    end
    if (!seen) check("moc_timeout", 32'd0, 32'd1);
    else       check("moc_latency", n - 1, EXP_LAT);
    for (int i = 0; i < hold_extra; i++) begin
      @(negedge clk);
      check("hold_moc",  {31'd0, bus.MOC}, 32'd1);
      check("hold_data", bus.DataOut, exp_d);
    end
    bus.MOV = 1'b0;
    // Scramble inputs once the request is latched; they must not matter.
    bus.addr = ~a; bus.OpC = ~op; bus.DataIn = ~din; bus.RW = ~rw;
    @(negedge clk);
    check("moc_fall", {31'd0, bus.MOC}, 32'd0);
  endtask

  initial begin
    int high_cnt;
    reset = 1'b0;
    bus.MOV = 1'b0; bus.RW = 1'b1; bus.addr = '0; bus.DataIn = '0; bus.OpC = '0;

    @(negedge clk);
    dut.Mem[0]  = 8'h8C; dut.Mem[1]  = 8'h01; dut.Mem[2]  = 8'h00; dut.Mem[3]  = 8'h04;
    dut.Mem[5]  = 8'hF0;
    dut.Mem[8]  = 8'hDE; dut.Mem[9]  = 8'hAD; dut.Mem[10] = 8'hBE; dut.Mem[11] = 8'hEF;
    dut.Mem[12] = 8'h11; dut.Mem[13] = 8'h22; dut.Mem[14] = 8'h33; dut.Mem[15] = 8'h44;
    @(negedge clk);

    check("rst_moc",   {31'd0, bus.MOC},  32'd0);
    check("rst_dmoc",  {31'd0, bus.DMOC}, 32'd0);
    check("rst_err",   {31'd0, bus.ERR},  32'd0);
    check("rst_data",  bus.DataOut,       32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b1;

    do_req(1'b1, 9'd0, OP_LW,  32'd0, 32'h8C010004, 1'b0, 1'b1, 0);
    do_req(1'b1, 9'd5, OP_LB,  32'd0, 32'hFFFFFFF0, 1'b0, 1'b1, 0);
    do_req(1'b1, 9'd5, OP_LBU, 32'd0, 32'h000000F0, 1'b0, 1'b1, 0);
    // write leaves DataOut at the previous read value
    do_req(1'b0, 9'd6, OP_SH,  32'h0000ABCD, 32'h000000F0, 1'b0, 1'b1, 0);
    check("sh_mem5", {24'd0, dut.Mem[5]}, 32'hF0);
    check("sh_mem6", {24'd0, dut.Mem[6]}, 32'hAB);
    check("sh_mem7", {24'd0, dut.Mem[7]}, 32'hCD);
    check("sh_mem8", {24'd0, dut.Mem[8]}, 32'hDE);
    do_req(1'b1, 9'd6, OP_LHU, 32'd0, 32'h0000ABCD, 1'b0, 1'b1, 0);
    do_req(1'b1, 9'd6, OP_LH,  32'd0, 32'hFFFFABCD, 1'b0, 1'b1, 0);

    do_req(1'b1, 9'd2, OP_LW,  32'd0, 32'h00000000, 1'b1, 1'b1, 0);
    do_req(1'b0, 9'd3, OP_SW,  32'h12345678, 32'h00000000, 1'b1, 1'b1, 0);
    check("sw_mis_mem3", {24'd0, dut.Mem[3]}, 32'h04);
    check("sw_mis_mem4", {24'd0, dut.Mem[4]}, 32'h00);
    check("sw_mis_mem5", {24'd0, dut.Mem[5]}, 32'hF0);
    check("sw_mis_mem6", {24'd0, dut.Mem[6]}, 32'hAB);

    // instruction fetch, MOV held 5 extra cycles
    do_req(1'b1, 9'd8, OP_IF,  32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 5);

    do_req(1'b0, 9'd511, OP_SB, 32'h123456A5, 32'hDEADBEEF, 1'b0, 1'b1, 0);
    check("sb511_mem", {24'd0, dut.Mem[511]}, 32'hA5);
    do_req(1'b1, 9'd511, OP_LBU, 32'd0, 32'h000000A5, 1'b0, 1'b1, 0);

    // store opcode with RW=1 reads
    do_req(1'b1, 9'd0, OP_SW, 32'hFFFFFFFF, 32'h8C010004, 1'b0, 1'b1, 0);
    check("sw_rd_mem0", {24'd0, dut.Mem[0]}, 32'h8C);

    // MOV dropped while BUSY, inputs changed: access completes, MOC one cycle
    exp_q.push_back({32'hDEADBEEF, 1'b0, 1'b1});
    bus.RW = 1'b1; bus.addr = 9'd8; bus.OpC = OP_LW; bus.MOV = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.MOV = 1'b0; bus.addr = 9'd0; bus.OpC = OP_LB; bus.RW = 1'b0;
    high_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.MOC === 1'b1) high_cnt++;
    end
    check("drop_moc_cycles", high_cnt, 32'd1);
    check("drop_state", {30'd0, state_dbg}, 32'd0);

    // reset during a BUSY store
    bus.RW = 1'b0; bus.addr = 9'd12; bus.OpC = OP_SW; bus.DataIn = 32'hCAFEF00D; bus.MOV = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_moc",   {31'd0, bus.MOC},  32'd0);
    check("abort_dmoc",  {31'd0, bus.DMOC}, 32'd0);
    check("abort_err",   {31'd0, bus.ERR},  32'd0);
    check("abort_data",  bus.DataOut,       32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    bus.MOV = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_mem12", {24'd0, dut.Mem[12]}, 32'h11);
    check("abort_mem13", {24'd0, dut.Mem[13]}, 32'h22);
    check("abort_mem14", {24'd0, dut.Mem[14]}, 32'h33);
    check("abort_mem15", {24'd0, dut.Mem[15]}, 32'h44);
    reset = 1'b1;

    do_req(1'b1, 9'd12, OP_LW, 32'd0, 32'h11223344, 1'b0, 1'b1, 0);
    do_req(1'b0, 9'd12, OP_SW, 32'hCAFEF00D, 32'h11223344, 1'b0, 1'b1, 0);
    do_req(1'b1, 9'd12, OP_LW, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
